// File: rtl/ctx_arb_pkg.sv
// Shared types and constants for the context/data memory arbiter.
// The perf counter width here also sizes the CTX_ARB_PERF_EN counter ports.
package ctx_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int PERF_CNT_W = 32;

  // A channel ID needs at least one bit even when only one channel exists.
  function automatic int ch_id_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/ctx_arb_id_fifo.sv
// In-order FIFO of issuing-channel IDs, one entry per outstanding memory transaction.
// Pushes while full and pops while empty are ignored.
module ctx_arb_id_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_id,
  input  logic                       pop,
  output logic [W-1:0]               head_id,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head_id = mem[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_id;
  end

endmodule

// File: rtl/ctx_mem_arbiter.sv
// Lock-on-request N-channel arbiter merging core data and RTOS context traffic onto one OBI port.
// Optional per-channel grant/stall counters are built when CTX_ARB_PERF_EN is defined.
module ctx_mem_arbiter
  import ctx_arb_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_OUTST = 4,
  parameter int ARB_MODE  = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH-1:0]            ch_req_i,
  input  logic [NUM_CH-1:0]            ch_we_i,
  input  logic [NUM_CH*(DW/8)-1:0]     ch_be_i,
  input  logic [NUM_CH*AW-1:0]         ch_addr_i,
  input  logic [NUM_CH*DW-1:0]         ch_wdata_i,
  output logic [NUM_CH-1:0]            ch_gnt_o,
  output logic [NUM_CH-1:0]            ch_rvalid_o,
  output logic [DW-1:0]                ch_rdata_o,
  output logic                         mem_req_o,
  input  logic                         mem_gnt_i,
  output logic                         mem_we_o,
  output logic [DW/8-1:0]              mem_be_o,
  output logic [AW-1:0]                mem_addr_o,
  output logic [DW-1:0]                mem_wdata_o,
  input  logic                         mem_rvalid_i,
  input  logic [DW-1:0]                mem_rdata_i,
  output logic                         err_o,
  output logic [NUM_CH*PERF_CNT_W-1:0] perf_grant_cnt_o,
  output logic [NUM_CH*PERF_CNT_W-1:0] perf_stall_cnt_o
);

  localparam int        IDW  = ch_id_w(NUM_CH);
  localparam int        BW   = DW / 8;
  localparam arb_mode_e MODE = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

  logic                        lock_q;
  logic [IDW-1:0]              lock_ch_q;
  logic [IDW-1:0]              rr_ptr_q;
  logic [IDW-1:0]              base;
  logic [IDW-1:0]              pick;
  logic [IDW:0]                idx_w;
  logic                        pick_found;
  logic [IDW-1:0]              sel;
  logic [NUM_CH-1:0]           sel_oh;
  logic                        any_req;
  logic                        grant;
  logic                        rsp_pop;
  logic                        stray_rsp;
  logic                        err_q;
  logic [IDW-1:0]              head_id;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(MAX_OUTST):0]  fifo_cnt;

  // Search starts at the RR pointer in round-robin mode, at channel 0 otherwise.
  assign base = (MODE == ARB_RR) ? rr_ptr_q : '0;

  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    idx_w      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx_w = {1'b0, base} + (IDW+1)'(i);
      if (idx_w >= (IDW+1)'(NUM_CH)) idx_w = idx_w - (IDW+1)'(NUM_CH);
      if (!pick_found && ch_req_i[idx_w[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick       = idx_w[IDW-1:0];
      end
    end
  end

  assign sel       = lock_q ? lock_ch_q : pick;
  assign sel_oh    = NUM_CH'(1) << sel;
  assign any_req   = |ch_req_i;
  assign mem_req_o = (any_req | lock_q) & ~fifo_full;
  assign grant     = mem_req_o & mem_gnt_i;
  assign ch_gnt_o  = grant ? sel_oh : '0;

  // Payload is forced to zero whenever no request is presented to memory.
  assign mem_we_o    = mem_req_o & ch_we_i[sel];
  assign mem_be_o    = mem_req_o ? ch_be_i[int'(sel)*BW +: BW] : '0;
  assign mem_addr_o  = mem_req_o ? ch_addr_i[int'(sel)*AW +: AW] : '0;
  assign mem_wdata_o = mem_req_o ? ch_wdata_i[int'(sel)*DW +: DW] : '0;

  assign rsp_pop     = mem_rvalid_i & ~fifo_empty;
  assign stray_rsp   = mem_rvalid_i & (fifo_cnt == '0);
  assign ch_rvalid_o = rsp_pop ? (NUM_CH'(1) << head_id) : '0;
  assign ch_rdata_o  = rsp_pop ? mem_rdata_i : '0;
  assign err_o       = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      rr_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (mem_req_o && !mem_gnt_i) begin
        lock_q    <= 1'b1;
        lock_ch_q <= sel;
      end else if (grant) begin
        lock_q <= 1'b0;
      end
      if (grant) rr_ptr_q <= (sel == IDW'(NUM_CH-1)) ? '0 : sel + 1'b1;
      if (stray_rsp) err_q <= 1'b1;
    end
  end

  ctx_arb_id_fifo #(
    .W     (IDW),
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (grant),
    .push_id (sel),
    .pop     (rsp_pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

`ifdef CTX_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] grant_cnt_q [NUM_CH];
  logic [PERF_CNT_W-1:0] stall_cnt_q [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_perf
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        grant_cnt_q[c] <= '0;
        stall_cnt_q[c] <= '0;
      end else begin
        if (ch_gnt_o[c] && (grant_cnt_q[c] != '1)) grant_cnt_q[c] <= grant_cnt_q[c] + 1'b1;
        if (ch_req_i[c] && !ch_gnt_o[c] && (stall_cnt_q[c] != '1))
          stall_cnt_q[c] <= stall_cnt_q[c] + 1'b1;
      end
    end
    assign perf_grant_cnt_o[c*PERF_CNT_W +: PERF_CNT_W] = grant_cnt_q[c];
    assign perf_stall_cnt_o[c*PERF_CNT_W +: PERF_CNT_W] = stall_cnt_q[c];
  end
`else
  assign perf_grant_cnt_o = '0;
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ctx_mem_arbiter.sv
// Bench for ctx_mem_arbiter: a fixed-priority and a round-robin instance, each checked every cycle
// against a transaction-level model (pending requests, ID queue, lock owner, pointer, counts).
module tb_ctx_mem_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req [2];
  logic [N-1:0]    we [2];
  logic [N*BW-1:0] be [2];
  logic [N*AW-1:0] addr [2];
  logic [N*DW-1:0] wd [2];
  logic            mgnt [2];
  logic            mrv [2];
  logic [DW-1:0]   mrd [2];

  logic [N-1:0]    gnt_o [2];
  logic [N-1:0]    rv_o [2];
  logic [DW-1:0]   rd_o [2];
  logic            mreq_o [2];
  logic            mwe_o [2];
  logic [BW-1:0]   mbe_o [2];
  logic [AW-1:0]   maddr_o [2];
  logic [DW-1:0]   mwd_o [2];
  logic            err_o [2];
  logic [N*32-1:0] pg_o [2];
  logic [N*32-1:0] ps_o [2];

  ctx_mem_arbiter #(.NUM_CH(N), .AW(AW), .DW(DW), .MAX_OUTST(D), .ARB_MODE(0)) u_fixed (
    .clk_i(clk), .rst_i(rst), .ch_req_i(req[0]), .ch_we_i(we[0]), .ch_be_i(be[0]),
    .ch_addr_i(addr[0]), .ch_wdata_i(wd[0]), .ch_gnt_o(gnt_o[0]), .ch_rvalid_o(rv_o[0]),
    .ch_rdata_o(rd_o[0]), .mem_req_o(mreq_o[0]), .mem_gnt_i(mgnt[0]), .mem_we_o(mwe_o[0]),
    .mem_be_o(mbe_o[0]), .mem_addr_o(maddr_o[0]), .mem_wdata_o(mwd_o[0]),
    .mem_rvalid_i(mrv[0]), .mem_rdata_i(mrd[0]), .err_o(err_o[0]),
    .perf_grant_cnt_o(pg_o[0]), .perf_stall_cnt_o(ps_o[0]));

  ctx_mem_arbiter #(.NUM_CH(N), .AW(AW), .DW(DW), .MAX_OUTST(D), .ARB_MODE(1)) u_rr (
    .clk_i(clk), .rst_i(rst), .ch_req_i(req[1]), .ch_we_i(we[1]), .ch_be_i(be[1]),
    .ch_addr_i(addr[1]), .ch_wdata_i(wd[1]), .ch_gnt_o(gnt_o[1]), .ch_rvalid_o(rv_o[1]),
    .ch_rdata_o(rd_o[1]), .mem_req_o(mreq_o[1]), .mem_gnt_i(mgnt[1]), .mem_we_o(mwe_o[1]),
    .mem_be_o(mbe_o[1]), .mem_addr_o(maddr_o[1]), .mem_wdata_o(mwd_o[1]),
    .mem_rvalid_i(mrv[1]), .mem_rdata_i(mrd[1]), .err_o(err_o[1]),
    .perf_grant_cnt_o(pg_o[1]), .perf_stall_cnt_o(ps_o[1]));

  // Model state
  int    lock_ch [2];
  int    rr [2];
  int    qbuf [2][D];
  int    qhead [2];
  int    qcnt [2];
  bit    err_m [2];
  longint pgc [2][N];
  longint psc [2][N];
  logic [N-1:0] m_gnt [2];

  // Samples taken at each evaluation, used by the literal checks
  logic [N-1:0]  s_gnt [2];
  logic [N-1:0]  s_rv [2];
  logic          s_req [2];
  logic [AW-1:0] s_addr [2];
  logic [DW-1:0] s_rd [2];
  logic          s_err [2];

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      lock_ch[k] = -1;
      rr[k]      = 0;
      qhead[k]   = 0;
      qcnt[k]    = 0;
      err_m[k]   = 1'b0;
      m_gnt[k]   = '0;
      for (int c = 0; c < N; c++) begin
        pgc[k][c] = 0;
        psc[k][c] = 0;
      end
    end
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      req[k] = '0; we[k] = '0; be[k] = '0; addr[k] = '0; wd[k] = '0;
      mgnt[k] = 1'b0; mrv[k] = 1'b0; mrd[k] = '0;
    end
  endtask

  task automatic set_ch(input int k, input int c, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    req[k][c] = 1'b1;
    we[k][c]  = w;
    be[k][c*BW +: BW]   = 4'hF;
    addr[k][c*AW +: AW] = a;
    wd[k][c*DW +: DW]   = d;
  endtask

  task automatic eval(input int k);
    string        tag;
    int           sel;
    bit           found, locked, ereq, grant, pop, stray;
    logic [N-1:0] one_h, egnt, erv;
    logic [63:0]  exp_cnt;
    tag   = (k == 1) ? "rr" : "fx";
    one_h = 1;
    s_gnt[k] = gnt_o[k]; s_rv[k] = rv_o[k]; s_req[k] = mreq_o[k];
    s_addr[k] = maddr_o[k]; s_rd[k] = rd_o[k]; s_err[k] = err_o[k];

    locked = (lock_ch[k] >= 0);
    ereq   = ((req[k] != '0) || locked) && (qcnt[k] < D);
    sel    = 0;
    found  = 0;
    if (locked) sel = lock_ch[k];
    else begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (((k == 1) ? rr[k] : 0) + i) % N;
        if (!found && req[k][c]) begin
          found = 1;
          sel   = c;
        end
      end
    end
    grant = ereq && mgnt[k];
    egnt  = grant ? (one_h << sel) : '0;
    pop   = mrv[k] && (qcnt[k] > 0);
    stray = mrv[k] && (qcnt[k] == 0);
    erv   = pop ? (one_h << qbuf[k][qhead[k]]) : '0;

    check({tag, ".mem_req"}, 64'(mreq_o[k]), 64'(ereq));
    check({tag, ".gnt"}, 64'(gnt_o[k]), 64'(egnt));
    check({tag, ".rvalid"}, 64'(rv_o[k]), 64'(erv));
    check({tag, ".err"}, 64'(err_o[k]), 64'(err_m[k]));
    if (ereq) begin
      check({tag, ".addr"}, 64'(maddr_o[k]), 64'(addr[k][sel*AW +: AW]));
      check({tag, ".we"}, 64'(mwe_o[k]), 64'(we[k][sel]));
      check({tag, ".be"}, 64'(mbe_o[k]), 64'(be[k][sel*BW +: BW]));
      check({tag, ".wdata"}, 64'(mwd_o[k]), 64'(wd[k][sel*DW +: DW]));
    end
    if (pop) check({tag, ".rdata"}, 64'(rd_o[k]), 64'(mrd[k]));
    for (int c = 0; c < N; c++) begin
`ifdef CTX_ARB_PERF_EN
      exp_cnt = 64'(pgc[k][c]);
`else
      exp_cnt = 64'd0;
`endif
      check($sformatf("%s.perf_gnt%0d", tag, c), 64'(pg_o[k][c*32 +: 32]), exp_cnt);
`ifdef CTX_ARB_PERF_EN
      exp_cnt = 64'(psc[k][c]);
`endif
      check($sformatf("%s.perf_stall%0d", tag, c), 64'(ps_o[k][c*32 +: 32]), exp_cnt);
    end

    if (stray) err_m[k] = 1'b1;
    if (pop) begin
      qhead[k] = (qhead[k] + 1) % D;
      qcnt[k]--;
    end
    if (grant) begin
      qbuf[k][(qhead[k] + qcnt[k]) % D] = sel;
      qcnt[k]++;
      rr[k] = (sel + 1) % N;
    end
    if (ereq && !mgnt[k]) lock_ch[k] = sel;
    else if (grant) lock_ch[k] = -1;
    for (int c = 0; c < N; c++) begin
      if (egnt[c]) pgc[k][c]++;
      if (req[k][c] && !egnt[c]) psc[k][c]++;
    end
    m_gnt[k] = egnt;
  endtask

  // Inputs are driven at the falling edge; evaluation happens 1 ns later.
  task automatic step();
    #1;
    for (int k = 0; k < 2; k++) eval(k);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst.mem_req", 64'(mreq_o[k]), 64'd0);
      check("rst.gnt", 64'(gnt_o[k]), 64'd0);
      check("rst.rvalid", 64'(rv_o[k]), 64'd0);
      check("rst.rdata", 64'(rd_o[k]), 64'd0);
      check("rst.err", 64'(err_o[k]), 64'd0);
      check("rst.addr", 64'(maddr_o[k]), 64'd0);
      check("rst.wdata", 64'(mwd_o[k]), 64'd0);
      check("rst.be_we", 64'({mbe_o[k], mwe_o[k]}), 64'd0);
      check("rst.perf", 64'(|{pg_o[k], ps_o[k]}), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < N; c++) begin
        if (req[k][c] && m_gnt[k][c]) req[k][c] = 1'b0;
        if (!req[k][c] && ($urandom_range(0, 2) == 0))
          set_ch(k, c, 1'($urandom), $urandom, $urandom);
        if (req[k][c]) be[k][c*BW +: BW] = be[k][c*BW +: BW];
      end
      mgnt[k] = ($urandom_range(0, 3) != 0);
      mrv[k]  = (qcnt[k] > 0) && ($urandom_range(0, 2) != 0);
      mrd[k]  = $urandom;
    end
  endtask

  initial begin
    logic [N-1:0] rr_seq [6];
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    idle();
    do_reset();

    // Fixed priority: ch0 beats ch2, ch2 follows
    set_ch(0, 0, 1'b0, 32'h100, 32'h0);
    set_ch(0, 2, 1'b1, 32'h300, 32'h33);
    mgnt[0] = 1'b1;
    step();
    check("t1.first", 64'(s_gnt[0]), 64'(3'b001));
    req[0][0] = 1'b0;
    step();
    check("t1.second", 64'(s_gnt[0]), 64'(3'b100));
    req[0] = '0; mgnt[0] = 1'b0;
    mrv[0] = 1'b1; mrd[0] = 32'hA;
    step();
    check("t1.rsp0", 64'({s_rv[0], s_rd[0]}), 64'({3'b001, 32'hA}));
    mrd[0] = 32'hB;
    step();
    check("t1.rsp2", 64'({s_rv[0], s_rd[0]}), 64'({3'b100, 32'hB}));
    mrv[0] = 1'b0;

    // Lock holds ch1 while ch0 arrives
    set_ch(0, 1, 1'b1, 32'h1111_0000, 32'h5555);
    step();
    set_ch(0, 0, 1'b0, 32'h0000_00A0, 32'h0);
    step();
    check("t2.addr_a", 64'(s_addr[0]), 64'h1111_0000);
    step();
    check("t2.addr_b", 64'(s_addr[0]), 64'h1111_0000);
    mgnt[0] = 1'b1;
    step();
    check("t2.gnt_ch1", 64'(s_gnt[0]), 64'(3'b010));
    req[0][1] = 1'b0;
    step();
    check("t2.gnt_ch0", 64'(s_gnt[0]), 64'(3'b001));
    req[0] = '0; mgnt[0] = 1'b0; mrv[0] = 1'b1;
    repeat (2) step();
    mrv[0] = 1'b0;

    // Interleaved ch2, ch0, ch1 then ordered responses
    mgnt[0] = 1'b1;
    set_ch(0, 2, 1'b0, 32'h20, 32'h0); step(); req[0] = '0;
    set_ch(0, 0, 1'b0, 32'h40, 32'h0); step(); req[0] = '0;
    set_ch(0, 1, 1'b0, 32'h60, 32'h0); step(); req[0] = '0;
    mgnt[0] = 1'b0; mrv[0] = 1'b1;
    mrd[0] = 32'hA; step();
    check("t5.r1", 64'({s_rv[0], s_rd[0]}), 64'({3'b100, 32'hA}));
    mrd[0] = 32'hB; step();
    check("t5.r2", 64'({s_rv[0], s_rd[0]}), 64'({3'b001, 32'hB}));
    mrd[0] = 32'hC; step();
    check("t5.r3", 64'({s_rv[0], s_rd[0]}), 64'({3'b010, 32'hC}));
    mrv[0] = 1'b0;

    // Round-robin with continuous requests and same-cycle push/pop
    for (int c = 0; c < N; c++) set_ch(1, c, 1'b0, 32'(c * 16), 32'h0);
    mgnt[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mrv[1] = (i > 0);
      step();
      check($sformatf("t3.rr%0d", i), 64'(s_gnt[1]), 64'(rr_seq[i]));
    end
    req[1] = '0; mgnt[1] = 1'b0; mrv[1] = 1'b1;
    step();
    mrv[1] = 1'b0;

    // FIFO full blocks requests, no bypass on pop
    set_ch(0, 0, 1'b1, 32'h80, 32'h8);
    mgnt[0] = 1'b1;
    repeat (4) step();
    step();
    check("t4.full_req", 64'({s_req[0], s_gnt[0]}), 64'd0);
    mrv[0] = 1'b1;
    step();
    check("t4.pop_rv", 64'(s_rv[0]), 64'(3'b001));
    check("t4.no_bypass", 64'(s_req[0]), 64'd0);
    mrv[0] = 1'b0;
    step();
    check("t4.resume", 64'(s_req[0]), 64'd1);
    req[0] = '0; mgnt[0] = 1'b0; mrv[0] = 1'b1;
    repeat (4) step();
    mrv[0] = 1'b0;

    // Random traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      step();
    end
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 2; k++) begin
        req[k]  = '0;
        mgnt[k] = 1'b1;
        mrv[k]  = (qcnt[k] > 0);
      end
      step();
    end
    idle();

    // Stray response sets a sticky error
    mrv[0] = 1'b1;
    step();
    mrv[0] = 1'b0;
    step();
    check("t6.err_set", 64'(s_err[0]), 64'd1);
    step();
    check("t6.err_sticky", 64'(s_err[0]), 64'd1);

    // Reset with two outstanding, then a stray response
    set_ch(0, 1, 1'b0, 32'hC0, 32'h0);
    mgnt[0] = 1'b1;
    repeat (2) step();
    do_reset();
    mrv[0] = 1'b1;
    step();
    check("t6.rv_after_rst", 64'(s_rv[0]), 64'd0);
    mrv[0] = 1'b0;
    step();
    check("t6.err_after_rst", 64'(s_err[0]), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
